enoc_input_unit: RTL and testbench

Per-port input buffer feeding the ENoC switch controller. Accepts flits from the upstream link under valid/enable flow control and stores them in a circular FIFO. It presents the head flit's destination as a one-hot output-port request to the switch controller and pops the head flit when the controller grants this input. It is the requester/consumer side of the switch-control request/grant handshake; one instance sits on each of the N router inputs (non-VOQ configuration).

---
 rtl/enoc_input_unit.sv | 102 ++++++++++
 tb/tb_enoc_input_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/enoc_input_unit.sv
// ENoC router input unit: circular flit FIFO that issues a one-hot output-port
// request for its head flit and pops it on grant. Option: ENOC_EN_SLACK_EN.
module enoc_input_unit #(
  parameter int unsigned M          = 5,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned DEST_W    = (M > 1) ? $clog2(M) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DEST_W-1:0]     i_dest,
  input  logic                  i_data_val,
  output logic                  o_en,
  output logic [M-1:0]          o_output_req,
  input  logic                  i_input_grant,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_val,
  output logic                  o_overflow,
  output logic                  o_bad_dest
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [DEST_W-1:0]     mem_dest [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic              empty;
  logic              full;
  logic              dest_ok;
  logic              push;
  logic              pop;
  logic [DEST_W-1:0] head_dest;

  // Push/pop qualification; fullness is judged on the start-of-cycle count.
  always_comb begin
    empty     = 1'b0;
    full      = 1'b0;
    dest_ok   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    head_dest = mem_dest[rd_ptr];
    empty     = (count == '0);
    full      = (count == CNT_W'(DEPTH));
    dest_ok   = ({1'b0, i_dest} < (DEST_W + 1)'(M));
    push      = ce && i_data_val && !full && dest_ok;
    pop       = ce && i_input_grant && !empty;
  end

  // Pointer, occupancy and status flag state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
      o_bad_dest <= 1'b0;
    end else if (ce) begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (i_data_val && full) o_overflow <= 1'b1;
      o_bad_dest <= i_data_val && !dest_ok;
    end
  end

  // Flit storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= i_data;
      mem_dest[wr_ptr] <= i_dest;
    end
  end

`ifdef ENOC_EN_SLACK_EN
  assign o_en = (count < CNT_W'(DEPTH - 1));
`else
  assign o_en = (count < CNT_W'(DEPTH));
`endif

  // Head request decodes from registered state only, independent of grant.
  always_comb begin
    o_output_req = '0;
    for (int unsigned j = 0; j < M; j++) begin
      o_output_req[j] = !empty && (head_dest == DEST_W'(j));
    end
  end

  assign o_data     = mem_data[rd_ptr];
  assign o_data_val = pop;

endmodule

// File: tb/tb_enoc_input_unit.sv
// Directed bench for enoc_input_unit with a queue scoreboard checked every cycle.
module tb_enoc_input_unit;

  localparam int unsigned M      = 5;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DW     = 32;
  localparam int unsigned DEST_W = 3;
`ifdef ENOC_EN_SLACK_EN
  localparam int unsigned EN_LIM = DEPTH - 1;
`else
  localparam int unsigned EN_LIM = DEPTH;
`endif

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DW-1:0]     data;
  } flit_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              ce;
  logic [DW-1:0]     i_data;
  logic [DEST_W-1:0] i_dest;
  logic              i_data_val;
  logic              o_en;
  logic [M-1:0]      o_output_req;
  logic              i_input_grant;
  logic [DW-1:0]     o_data;
  logic              o_data_val;
  logic              o_overflow;
  logic              o_bad_dest;

  int n_cmp = 0;
  int n_bad = 0;

  flit_t q[$];
  logic  exp_ovf;
  logic  exp_bad;

  enoc_input_unit #(.M(M), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .ce(ce), .i_data(i_data), .i_dest(i_dest),
    .i_data_val(i_data_val), .o_en(o_en), .o_output_req(o_output_req),
    .i_input_grant(i_input_grant), .o_data(o_data), .o_data_val(o_data_val),
    .o_overflow(o_overflow), .o_bad_dest(o_bad_dest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compare every output against the scoreboard, then advance the model.
  task automatic check_and_update();
    logic         full_s;
    logic         val_e;
    logic [M-1:0] req_e;
    req_e  = '0;
    full_s = (q.size() == DEPTH);
    val_e  = ce && i_input_grant && (q.size() > 0);
    if (q.size() > 0) req_e[q[0].dest] = 1'b1;
    chk("o_en", 64'(o_en), 64'(q.size() < EN_LIM));
    chk("o_output_req", 64'(o_output_req), 64'(req_e));
    chk("o_data_val", 64'(o_data_val), 64'(val_e));
    if (q.size() > 0) chk("o_data", 64'(o_data), 64'(q[0].data));
    chk("o_overflow", 64'(o_overflow), 64'(exp_ovf));
    chk("o_bad_dest", 64'(o_bad_dest), 64'(exp_bad));
    if (ce) begin
      if (i_data_val && full_s) exp_ovf = 1'b1;
      exp_bad = i_data_val && (i_dest >= DEST_W'(M));
      if (val_e) void'(q.pop_front());
      if (i_data_val && !full_s && (i_dest < DEST_W'(M))) q.push_back('{dest: i_dest, data: i_data});
    end
  endtask

  task automatic step(input logic v, input logic [DEST_W-1:0] d, input logic [DW-1:0] dat,
                      input logic g, input logic c);
    i_data_val    = v;
    i_dest        = d;
    i_data        = dat;
    i_input_grant = g;
    ce            = c;
    @(negedge clk);
    check_and_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"}, 64'(o_en), 64'(1));
    chk({tag, "_req"}, 64'(o_output_req), 64'(0));
    chk({tag, "_val"}, 64'(o_data_val), 64'(0));
    chk({tag, "_ovf"}, 64'(o_overflow), 64'(0));
    chk({tag, "_bad"}, 64'(o_bad_dest), 64'(0));
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; i_data = '0; i_dest = '0; i_data_val = 1'b0; i_input_grant = 1'b0;
    exp_ovf = 1'b0; exp_bad = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Single flit held without grant, then granted.
    step(1'b1, 3'd2, 32'hA5, 1'b0, 1'b1);
    chk("first_req", 64'(o_output_req), 64'(5'b00100));
    idle(10);
    step(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    idle(1);

    // Fill to full, overflow attempt, pop-with-rejected-push, drain.
    step(1'b1, 3'd0, 32'h10, 1'b0, 1'b1);
    step(1'b1, 3'd1, 32'h11, 1'b0, 1'b1);
    step(1'b1, 3'd3, 32'h13, 1'b0, 1'b1);
    step(1'b1, 3'd4, 32'h14, 1'b0, 1'b1);
    chk("full_en", 64'(o_en), 64'(0));
    step(1'b1, 3'd1, 32'hDEAD, 1'b0, 1'b1);
    step(1'b1, 3'd1, 32'hBEEF, 1'b1, 1'b1);
    chk("after_pop_en", 64'(o_en), 64'(EN_LIM > 3));
    step(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    idle(2);
    chk("ovf_sticky", 64'(o_overflow), 64'(1));

    // Bad destinations, on empty and on full FIFO.
    step(1'b1, 3'd5, 32'h55, 1'b0, 1'b1);
    idle(2);
    for (int k = 0; k < 4; k++) step(1'b1, 3'(k), 32'h20 + 32'(k), 1'b0, 1'b1);
    step(1'b1, 3'd7, 32'h77, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);

    // Clock enable low freezes everything.
    step(1'b1, 3'd3, 32'h33, 1'b0, 1'b0);
    step(1'b1, 3'd3, 32'h34, 1'b0, 1'b1);
    step(1'b1, 3'd1, 32'h35, 1'b1, 1'b0);
    step(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    idle(1);

    // Streaming: push and grant every cycle at a rolling destination.
    for (int k = 0; k < 20; k++) step(1'b1, 3'(k % 5), $urandom, 1'b1, 1'b1);
    step(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    idle(2);

    // Asynchronous reset in the middle of a loaded FIFO.
    for (int k = 0; k < 3; k++) step(1'b1, 3'(k + 1), 32'h40 + 32'(k), 1'b0, 1'b1);
    i_input_grant = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    exp_ovf = 1'b0;
    exp_bad = 1'b0;
    i_input_grant = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);
    step(1'b1, 3'd4, 32'h99, 1'b0, 1'b1);
    step(1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
